// File: rtl/flash_prog_if.sv
// Command/status bundle between the flash programming sequencer and its host/engines.
// verify_ok is present only when FLASH_PROG_VERIFY_EN is defined.
interface flash_prog_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32,
    parameter int SECT_W = 12
);
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [LEN_W-1:0]      data_len;
    logic [3:0]            cmd;
    logic                  cmd_valid;
    logic                  uart_done;
    logic                  flash_done;
    logic                  buff_empty;
`ifdef FLASH_PROG_VERIFY_EN
    logic                  verify_ok;
`endif
    logic [ADDR_W-1:0]     addr;
    logic [15:0]           rx_cnt;
    logic [LEN_W-SECT_W:0] sec_left;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, base_addr, data_len, uart_done, flash_done, buff_empty,
`ifdef FLASH_PROG_VERIFY_EN
        output verify_ok,
`endif
        input  cmd, cmd_valid, addr, rx_cnt, sec_left, busy, done, error
    );

    modport slave (
        input  start, base_addr, data_len, uart_done, flash_done, buff_empty,
`ifdef FLASH_PROG_VERIFY_EN
        input  verify_ok,
`endif
        output cmd, cmd_valid, addr, rx_cnt, sec_left, busy, done, error
    );
endinterface

// File: rtl/flash_prog_sequencer.sv
// Flash image programming sequencer: erase all sectors, then per-sector buffer/write/ack loop.
// Define FLASH_PROG_VERIFY_EN to read back and verify every written page (adds verify_ok).
module flash_prog_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32,
    parameter int PAGE_W = 8,
    parameter int SECT_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    flash_prog_if.slave bus
);
    // state   | meaning
    // IDLE    | wait for start           CALC   | sector count, argument check
    // ERS     | issue erase 0xA          WT_ERS | wait erase flash_done
    // REQ_BUF | issue buffer 0x7         WT_BUF | wait full page or sector received
    // WR_PG   | issue write 0xC          WT_PG  | wait write flash_done
    // RD_PG   | issue read 0xD           WT_RD  | wait read-back, check verify_ok
    // ACK     | issue ack 0x3            WT_ACK | wait uart_done of ack
    // FIN     | pulse done

    localparam int SC_W = LEN_W - SECT_W + 1;
    localparam int PC_W = SECT_W - PAGE_W + 1;
    localparam logic [ADDR_W-1:0] SECT_INC    = {{(ADDR_W-SECT_W-1){1'b0}}, 1'b1, {SECT_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PAGE_INC    = {{(ADDR_W-PAGE_W-1){1'b0}}, 1'b1, {PAGE_W{1'b0}}};
    localparam logic [PC_W-1:0]   PG_PER_SECT = {1'b1, {(PC_W-1){1'b0}}};
    localparam logic [15:0]       SECT_BYTES  = 16'(1 << SECT_W);

    localparam logic [3:0] CMD_ACK = 4'h3;
    localparam logic [3:0] CMD_BUF = 4'h7;
    localparam logic [3:0] CMD_ERS = 4'hA;
    localparam logic [3:0] CMD_WR  = 4'hC;
`ifdef FLASH_PROG_VERIFY_EN
    localparam logic [3:0] CMD_RD  = 4'hD;
`endif

    typedef enum logic [3:0] {
        IDLE, CALC, ERS, WT_ERS, REQ_BUF, WT_BUF, WR_PG, WT_PG,
`ifdef FLASH_PROG_VERIFY_EN
        RD_PG, WT_RD,
`endif
        ACK, WT_ACK, FIN
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       rx_cnt_q, rx_cnt_d;
    logic [SC_W-1:0]   sec_left_q, sec_left_d, ers_left_q, ers_left_d;
    logic [PC_W-1:0]   pg_cnt_q, pg_cnt_d;
    logic              flag_q, flag_d;
    logic [SC_W-1:0]   nsec;
    logic              arg_bad;
    logic              uart_win;

    assign nsec    = SC_W'(len_q >> SECT_W) + SC_W'(|len_q[SECT_W-1:0]);
    assign arg_bad = (len_q == '0) || (base_q[SECT_W-1:0] != '0);

`ifdef FLASH_PROG_VERIFY_EN
    assign uart_win = state_q inside {WT_BUF, WR_PG, WT_PG, RD_PG, WT_RD};
`else
    assign uart_win = state_q inside {WT_BUF, WR_PG, WT_PG};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            rx_cnt_q   <= '0;
            sec_left_q <= '0;
            ers_left_q <= '0;
            pg_cnt_q   <= '0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            rx_cnt_q   <= rx_cnt_d;
            sec_left_q <= sec_left_d;
            ers_left_q <= ers_left_d;
            pg_cnt_q   <= pg_cnt_d;
            flag_q     <= flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        base_d     = base_q;
        len_d      = len_q;
        rx_cnt_d   = rx_cnt_q;
        sec_left_d = sec_left_q;
        ers_left_d = ers_left_q;
        pg_cnt_d   = pg_cnt_q;
        flag_d     = flag_q;

        // Sector-received pulse is tracked independently so a coincident flash_done cannot mask it.
        if (uart_win && bus.uart_done) begin
            flag_d = 1'b1;
            if (sec_left_q != '0) sec_left_d = sec_left_q - SC_W'(1);
        end

        case (state_q)
            IDLE: if (bus.start) begin
                base_d  = bus.base_addr;
                len_d   = bus.data_len;
                state_d = CALC;
            end
            CALC: begin
                if (arg_bad) begin
                    state_d = IDLE;
                end else begin
                    addr_d     = base_q;
                    sec_left_d = nsec;
                    ers_left_d = nsec;
                    state_d    = ERS;
                end
            end
            ERS:     state_d = WT_ERS;
            WT_ERS: if (bus.flash_done) begin
                ers_left_d = ers_left_q - SC_W'(1);
                if (ers_left_q == SC_W'(1)) begin
                    addr_d  = base_q;
                    state_d = REQ_BUF;
                end else begin
                    addr_d  = addr_q + SECT_INC;
                    state_d = ERS;
                end
            end
            REQ_BUF: state_d = WT_BUF;
            WT_BUF: begin
                if (!bus.buff_empty && pg_cnt_q != '0) state_d = WR_PG;
                else if (pg_cnt_q == '0 && flag_q)     state_d = ACK;
            end
            WR_PG:   state_d = WT_PG;
`ifdef FLASH_PROG_VERIFY_EN
            WT_PG:   if (bus.flash_done) state_d = RD_PG;
            RD_PG:   state_d = WT_RD;
            WT_RD: if (bus.flash_done) begin
                if (bus.verify_ok) begin
                    addr_d   = addr_q + PAGE_INC;
                    pg_cnt_d = pg_cnt_q - PC_W'(1);
                    state_d  = WT_BUF;
                end else begin
                    state_d  = IDLE;
                end
            end
`else
            WT_PG: if (bus.flash_done) begin
                addr_d   = addr_q + PAGE_INC;
                pg_cnt_d = pg_cnt_q - PC_W'(1);
                state_d  = WT_BUF;
            end
`endif
            ACK:     state_d = WT_ACK;
            WT_ACK: if (bus.uart_done) state_d = (sec_left_q == '0) ? FIN : REQ_BUF;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Issuing states are one-cycle and never self-loop, so command data is loaded on entry.
        case (state_d)
            ERS:     cmd_d = CMD_ERS;
            REQ_BUF: begin
                cmd_d    = CMD_BUF;
                rx_cnt_d = SECT_BYTES;
                pg_cnt_d = PG_PER_SECT;
                flag_d   = 1'b0;
            end
            WR_PG:   cmd_d = CMD_WR;
`ifdef FLASH_PROG_VERIFY_EN
            RD_PG:   cmd_d = CMD_RD;
`endif
            ACK: begin
                cmd_d    = CMD_ACK;
                rx_cnt_d = 16'(sec_left_d);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.cmd_valid = 1'b0;
        bus.error     = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == FIN);
        case (state_q)
            ERS, REQ_BUF, WR_PG, ACK: bus.cmd_valid = 1'b1;
            CALC:                     bus.error     = arg_bad;
`ifdef FLASH_PROG_VERIFY_EN
            RD_PG:                    bus.cmd_valid = 1'b1;
            WT_RD:                    bus.error     = bus.flash_done && !bus.verify_ok;
`endif
            default: ;
        endcase
    end

    assign bus.cmd      = cmd_q;
    assign bus.addr     = addr_q;
    assign bus.rx_cnt   = rx_cnt_q;
    assign bus.sec_left = sec_left_q;
endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Scoreboard bench for flash_prog_sequencer: expected command stream queued at start, popped on cmd_valid.
// Engine responder models flash/UART completion; define FLASH_PROG_VERIFY_EN to exercise the verify path.
module tb_flash_prog_sequencer;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 32;
    localparam int PAGE_W = 8;
    localparam int SECT_W = 12;
`ifdef FLASH_PROG_VERIFY_EN
    localparam logic [3:0] PG_LAST = 4'hD;
`else
    localparam logic [3:0] PG_LAST = 4'hC;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    flash_prog_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SECT_W(SECT_W)) bus ();

    flash_prog_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PAGE_W(PAGE_W), .SECT_W(SECT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [15:0] rx;
        bit          chk_addr;
        bit          chk_rx;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_cmds = 0;

    int fd_t, ud_t, pg_in_sect, sect_idx, cur_nsec, co_sl;
    bit co_mode, co_armed, co_chk;
    logic [31:0] cur_base, co_addr;
`ifdef FLASH_PROG_VERIFY_EN
    int rd_cnt, fail_rd;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd"},       bus.cmd,       0);
        check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
        check({tag, "_addr"},      bus.addr,      0);
        check({tag, "_rx_cnt"},    bus.rx_cnt,    0);
        check({tag, "_sec_left"},  bus.sec_left,  0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_done"},      bus.done,      0);
        check({tag, "_error"},     bus.error,     0);
    endtask

    task automatic push_exp(input logic [3:0] c, input logic [31:0] a, input logic [15:0] rx,
                            input bit ca, input bit cr);
        exp_t e;
        e.cmd = c; e.addr = a; e.rx = rx; e.chk_addr = ca; e.chk_rx = cr;
        sb.push_back(e);
    endtask

    task automatic push_image(input logic [31:0] base, input logic [31:0] len, input int fail_at,
                              output bit exp_err);
        longint nsec;
        logic [31:0] a;
        int pg;
        bit stop;
        nsec    = (longint'(len) + 4095) / 4096;
        exp_err = (len == 0) || (base[11:0] != 12'h0);
        if (exp_err) return;
        a = base;
        for (longint s = 0; s < nsec; s++) begin
            push_exp(4'hA, a, 16'h0, 1'b1, 1'b0);
            a += 32'h1000;
        end
        a = base; pg = 0; stop = 1'b0;
        for (longint s = 0; s < nsec && !stop; s++) begin
            push_exp(4'h7, a, 16'h1000, 1'b0, 1'b1);
            for (int p = 0; p < 16 && !stop; p++) begin
                push_exp(4'hC, a, 16'h0, 1'b1, 1'b0);
`ifdef FLASH_PROG_VERIFY_EN
                push_exp(4'hD, a, 16'h0, 1'b1, 1'b0);
`endif
                if (pg == fail_at) stop = 1'b1;
                a += 32'h100;
                pg++;
            end
            if (!stop) push_exp(4'h3, 32'h0, 16'(nsec - 1 - s), 1'b0, 1'b1);
        end
        exp_err = stop;
    endtask

    task automatic setup_rsp(input logic [31:0] base, input logic [31:0] len, input bit co,
                             input int fail_at);
        fd_t = 0; ud_t = 0; co_armed = 1'b0; co_chk = 1'b0;
        co_mode = co; cur_base = base; sect_idx = 0; pg_in_sect = 0;
        cur_nsec = int'((longint'(len) + 4095) / 4096);
`ifdef FLASH_PROG_VERIFY_EN
        rd_cnt = 0; fail_rd = fail_at;
`else
        if (fail_at >= 0) $display("note: page failure injection needs the verify build");
`endif
    endtask

    task automatic run_image(input logic [31:0] base, input logic [31:0] len, input bit co,
                             input int fail_at);
        bit exp_err;
        int cyc, c0;
        push_image(base, len, fail_at, exp_err);
        setup_rsp(base, len, co, fail_at);
        c0 = n_cmds;
        @(negedge clk);
        bus.base_addr = base; bus.data_len = len; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.base_addr = ~base; bus.data_len = 32'h1;
        check("busy_calc", bus.busy, 1);
        cyc = 0;
        while (!bus.done && !bus.error && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == 30);
        end
        bus.start = 1'b0;
        check("end_done",  bus.done,  !exp_err);
        check("end_error", bus.error, exp_err);
        @(negedge clk);
        check("busy_after",  bus.busy, 0);
        check("pulse_width", bus.done | bus.error, 0);
        if (base[11:0] != 12'h0 || len == 0) check("no_cmd", n_cmds - c0, 0);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    // Engine responder: turns issued commands into delayed completion pulses.
    initial begin
        logic       new_cmd;
        logic [3:0] cv_cmd;
        bus.flash_done = 1'b0; bus.uart_done = 1'b0; bus.buff_empty = 1'b1;
`ifdef FLASH_PROG_VERIFY_EN
        bus.verify_ok = 1'b1;
`endif
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin
                fd_t = 0; ud_t = 0; co_armed = 1'b0; co_chk = 1'b0;
                bus.flash_done = 1'b0; bus.uart_done = 1'b0; bus.buff_empty = 1'b1;
                continue;
            end
            if (co_chk) begin
                check("coinc_sec_left", bus.sec_left, 64'(co_sl));
                check("coinc_addr",     bus.addr,     co_addr);
                co_chk = 1'b0;
            end
            new_cmd = bus.cmd_valid;
            cv_cmd  = bus.cmd;
            bus.flash_done = (fd_t == 1);
            bus.uart_done  = (ud_t == 1);
            if (fd_t > 0) fd_t--;
            if (ud_t > 0) ud_t--;
            if (bus.flash_done && bus.uart_done && co_armed) begin
                co_chk = 1'b1; co_armed = 1'b0;
            end
            bus.buff_empty = ($urandom_range(0, 3) == 0);
            if (new_cmd) begin
                case (cv_cmd)
                    4'hA: fd_t = $urandom_range(1, 4);
                    4'h7: begin
                        pg_in_sect = 0;
                        if (!co_mode) ud_t = $urandom_range(1, 40);
                    end
                    4'hC, 4'hD: begin
                        fd_t = $urandom_range(1, 3);
`ifdef FLASH_PROG_VERIFY_EN
                        if (cv_cmd == 4'hD) begin
                            bus.verify_ok = (rd_cnt != fail_rd);
                            rd_cnt++;
                        end
`endif
                        if (cv_cmd == PG_LAST) begin
                            pg_in_sect++;
                            if (co_mode && pg_in_sect == 16) begin
                                ud_t = fd_t; co_armed = 1'b1;
                                co_sl   = cur_nsec - sect_idx - 1;
                                co_addr = cur_base + 32'((sect_idx + 1) * 4096);
                            end
                        end
                    end
                    4'h3: begin
                        ud_t = $urandom_range(1, 3);
                        sect_idx++;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cmd_valid) begin
                n_cmds++;
                if (sb.size() == 0) begin
                    check("cmd_unexpected", bus.cmd, 0);
                end else begin
                    e = sb.pop_front();
                    check("cmd", bus.cmd, e.cmd);
                    if (e.chk_addr) check("cmd_addr", bus.addr, e.addr);
                    if (e.chk_rx)   check("cmd_rx_cnt", bus.rx_cnt, e.rx);
                end
            end
        end
    end

    initial begin
        bit e_err;
        int cyc;
        bus.start = 1'b0; bus.base_addr = '0; bus.data_len = '0;
        #1 rst_n = 1'b0;
        #2 check_zero("rst_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_image(32'h0000_0000, 32'h1000, 1'b0, -1);
        run_image(32'h0000_2000, 32'h1001, 1'b1, -1);
        run_image(32'h0000_4000, 32'h0,    1'b0, -1);
        run_image(32'h0000_1234, 32'h100,  1'b0, -1);
        run_image(32'hFFFF_F000, 32'h2000, 1'b1, -1);

        // Reset while programming the second sector, then a clean image.
        push_image(32'h2000, 32'h1001, -1, e_err);
        setup_rsp(32'h2000, 32'h1001, 1'b0, -1);
        @(negedge clk);
        bus.base_addr = 32'h2000; bus.data_len = 32'h1001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.cmd_valid && bus.cmd == 4'hC && sect_idx == 1) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reach", bus.cmd_valid, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_image(32'h0000_2000, 32'h1001, 1'b0, -1);

`ifdef FLASH_PROG_VERIFY_EN
        run_image(32'h0000_0000, 32'h1000, 1'b0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/flash_prog_sequencer.md
FLASH_PROG_SEQUENCER -- requirements
Module: flash_prog_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning flash byte-address width.
REQ-002 SHALL have parameter LEN_W, default 32, meaning image-length width in bytes.
REQ-003 SHALL have parameter PAGE_W, default 8, meaning log2 of page bytes (256).
REQ-004 SHALL have parameter SECT_W, default 12, meaning log2 of erase-sector bytes (4 KiB); SECT_W > PAGE_W.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle request to program an image.
REQ-008 SHALL have ports base_addr (input, ADDR_W) and data_len (input, LEN_W), sampled only on accepted start.
REQ-009 SHALL have ports cmd (output, 4) and cmd_valid (output, 1), meaning the macro command code and its one-cycle strobe.
REQ-010 SHALL have ports uart_done and flash_done (inputs, 1), meaning one-cycle completion pulses from the UART and flash engines.
REQ-011 SHALL have port buff_empty, input, 1, meaning the page buffer holds no complete page.
REQ-012 SHALL have ports addr (output, ADDR_W), rx_cnt (output, 16) and sec_left (output, LEN_W-SECT_W+1), meaning the current flash address, the byte/ack count for the UART engine, and the sectors still to program.
REQ-013 SHALL have ports busy, done and error (outputs, 1); done and error are one-cycle pulses.

Function
REQ-014 Command codes SHALL be: 0x3 ack-to-host, 0x7 buffer-sector, 0xA erase-sector, 0xC write-page, 0xD read-page.
REQ-015 States SHALL be IDLE, CALC, ERS, WT_ERS, REQ_BUF, WT_BUF, WR_PG, WT_PG, RD_PG, WT_RD, ACK, WT_ACK, FIN.
REQ-016 In IDLE, start SHALL be accepted and go to CALC; start SHALL be ignored in every other state.
REQ-017 In CALC, nsec = ceil(data_len / 2^SECT_W) SHALL be computed; data_len = 0 or base_addr[SECT_W-1:0] != 0 SHALL pulse error and return to IDLE without any command.
REQ-018 Each issuing state (ERS, REQ_BUF, WR_PG, RD_PG, ACK) SHALL assert cmd_valid for exactly one cycle, hold cmd until the next issue, and move to its wait state.
REQ-019 A done pulse SHALL be honoured from the cycle after cmd_valid; a pulse coincident with cmd_valid SHALL be ignored.
REQ-020 Erase phase: addr starts at base_addr; on each flash_done in WT_ERS, addr += 2^SECT_W; after nsec erases, addr SHALL reload base_addr and go to REQ_BUF.
REQ-021 REQ_BUF SHALL set rx_cnt = 2^SECT_W, a page counter = 2^(SECT_W-PAGE_W) and clear the sector-received flag.
REQ-022 In WT_BUF, buff_empty = 0 with page counter > 0 SHALL go to WR_PG; page counter = 0 with the flag set SHALL go to ACK.
REQ-023 uart_done in any of WT_BUF, WR_PG, WT_PG, RD_PG, WT_RD SHALL set the flag and decrement sec_left once; it SHALL not be lost when coincident with flash_done.
REQ-024 On flash_done in WT_PG, addr += 2^PAGE_W, page counter decrements and the FSM returns to WT_BUF.
REQ-025 ACK SHALL drive rx_cnt = sec_left (zero-extended/truncated to 16 bits); uart_done in WT_ACK goes to FIN if sec_left = 0, else REQ_BUF.
REQ-026 FIN SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-027 addr arithmetic SHALL wrap modulo 2^ADDR_W without flagging error.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, cmd = 0, cmd_valid = 0, addr = 0, rx_cnt = 0, sec_left = 0, busy = 0, done = 0, error = 0, counters and flag cleared, including mid-operation.

Configuration
REQ-029 With macro FLASH_PROG_VERIFY_EN defined, an input verify_ok (1) SHALL exist; WT_PG on flash_done SHALL go to RD_PG (cmd 0xD, same page address), and flash_done in WT_RD SHALL advance addr only if verify_ok = 1, else pulse error and return to IDLE.
REQ-030 Without FLASH_PROG_VERIFY_EN, verify_ok, RD_PG and WT_RD SHALL be absent and cmd 0xD SHALL never be issued.

Verification
REQ-031 base 0x0, len 0x1000 -> one 0xA at 0x0, one 0x7, sixteen 0xC at 0x000..0xF00, one 0x3 with rx_cnt 0, done.
REQ-032 base 0x2000, len 0x1001 -> 0xA at 0x2000 and 0x3000, two sector loops, acks rx_cnt 1 then 0, done.
REQ-033 len 0, or base 0x1234 -> error pulse, cmd_valid never asserted, busy 0 next cycle.
REQ-034 uart_done and flash_done coincident in WT_PG -> sec_left decrements once and addr advances 0x100 the same cycle.
REQ-035 rst_n low during WT_PG of sector 2 -> all outputs zero asynchronously; new start runs a full image normally.
REQ-036 FLASH_PROG_VERIFY_EN, verify_ok 0 on third page -> 0xD at 0x200, error pulse, IDLE, no further commands.
